dout_trace_buffer: RTL and testbench

Capture FIFO that sits directly downstream of the single-cycle datapath's `Dout` (ALU result) output. It samples the 32-bit result stream under a capture enable and buffers it for a slower consumer, such as a display scanner, serial dumper or testbench monitor. The consumer drains it through a valid/ready handshake. It adds an optional change-only filter, a selectable full-buffer policy, and a saturating overflow counter, so lost results are always accounted for.

---
 rtl/dout_trace_buffer.sv | 107 ++++++++++
 tb/tb_dout_trace_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dout_trace_buffer.sv
// Capture FIFO behind the datapath Dout: samples results under cap_en, buffers
// them for a slower valid/ready consumer, and counts every sample it loses.
module dout_trace_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter bit CHG_ONLY  = 1'b0,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] din,
    input  logic             clear,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic [15:0]      ovf_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt_q;
    logic             first;
    logic [WIDTH-1:0] last;

    logic qual;
    logic pop;
    logic store;
    logic overwrite_oldest;
    logic lost;
    logic flush;

    assign flush = Reset | clear;

    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rp];

    // A full buffer still accepts a sample when the consumer frees a slot in
    // the same cycle; otherwise the policy decides who is lost.
    always_comb begin
        qual             = cap_en & (!CHG_ONLY | first | (din != last));
        pop              = rd_valid & rd_ready;
        store            = 1'b0;
        overwrite_oldest = 1'b0;
        lost             = 1'b0;
        if (qual) begin
            if (!full || pop) begin
                store = 1'b1;
            end else begin
                lost = 1'b1;
                if (OVERWRITE) begin
                    store            = 1'b1;
                    overwrite_oldest = 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left unreset; only pointers and count matter.
    always_ff @(posedge clock) begin
        if (!flush && store) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wp      <= '0;
            rp      <= '0;
            cnt_q   <= '0;
            ovf_cnt <= '0;
            first   <= 1'b1;
            last    <= '0;
        end else begin
            if (store) begin
                wp <= wp + AW'(1);
            end
            if (pop || overwrite_oldest) begin
                rp <= rp + AW'(1);
            end
            if (store && !pop && !overwrite_oldest) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !store) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (lost && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
            // The change filter tracks every qualified sample, even dropped ones.
            if (qual) begin
                first <= 1'b0;
                last  <= din;
            end
        end
    end

endmodule

// File: tb/tb_dout_trace_buffer.sv
// Directed self-checking bench for dout_trace_buffer: three instances cover the
// drop policy, the overwrite policy and the change-only filter.
module tb_dout_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cap_en;
    logic [31:0] din;
    logic        clear;
    logic        rd_ready;

    logic        v0, v_ow, v_chg;
    logic [31:0] d0, d_ow, d_chg;
    logic [4:0]  c0, c_ow, c_chg;
    logic        f0, f_ow, f_chg;
    logic        e0, e_ow, e_chg;
    logic [15:0] o0, o_ow, o_chg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dout_trace_buffer #(.OVERWRITE(1'b0), .CHG_ONLY(1'b0)) dut0 (
        .clock(clock), .Reset(reset), .cap_en(cap_en), .din(din), .clear(clear),
        .rd_ready(rd_ready), .rd_valid(v0), .rd_data(d0), .count(c0),
        .full(f0), .empty(e0), .ovf_cnt(o0)
    );

    dout_trace_buffer #(.OVERWRITE(1'b1), .CHG_ONLY(1'b0)) dut_ow (
        .clock(clock), .Reset(reset), .cap_en(cap_en), .din(din), .clear(clear),
        .rd_ready(rd_ready), .rd_valid(v_ow), .rd_data(d_ow), .count(c_ow),
        .full(f_ow), .empty(e_ow), .ovf_cnt(o_ow)
    );

    dout_trace_buffer #(.OVERWRITE(1'b0), .CHG_ONLY(1'b1)) dut_chg (
        .clock(clock), .Reset(reset), .cap_en(cap_en), .din(din), .clear(clear),
        .rd_ready(rd_ready), .rd_valid(v_chg), .rd_data(d_chg), .count(c_chg),
        .full(f_chg), .empty(e_chg), .ovf_cnt(o_chg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic cap, input logic [31:0] d,
                                 input logic clr, input logic rdy);
        cap_en   = cap;
        din      = d;
        clear    = clr;
        rd_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cap_en = 1'b0; din = '0; clear = 1'b0; rd_ready = 1'b0;
        #2;
        doReset();
        checkOutput("reset_count", 32'(c0), 32'd0);
        checkOutput("reset_empty", 32'(e0), 32'd1);
        checkOutput("reset_full", 32'(f0), 32'd0);
        checkOutput("reset_valid", 32'(v0), 32'd0);
        checkOutput("reset_data", d0, 32'd0);
        checkOutput("reset_ovf", 32'(o0), 32'd0);

        // Basic ordering and first-word-fall-through.
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0);
        checkOutput("fwft_latency", d0, 32'd5);
        applyStimulus(1'b1, 32'd6, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd7, 1'b0, 1'b0);
        checkOutput("basic_count", 32'(c0), 32'd3);
        checkOutput("basic_head", d0, 32'd5);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("hold_head", d0, 32'd5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("basic_drain", d0, 32'(5 + i));
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        end
        checkOutput("basic_empty", 32'(e0), 32'd1);
        checkOutput("basic_data0", d0, 32'd0);

        // Fill past capacity: drop policy vs overwrite policy.
        doReset();
        for (int i = 1; i <= 18; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        checkOutput("drop_full", 32'(f0), 32'd1);
        checkOutput("drop_count", 32'(c0), 32'd16);
        checkOutput("drop_ovf", 32'(o0), 32'd2);
        checkOutput("ow_count", 32'(c_ow), 32'd16);
        checkOutput("ow_ovf", 32'(o_ow), 32'd2);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drop_order", d0, 32'(1 + i));
            checkOutput("ow_order", d_ow, 32'(3 + i));
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        end
        checkOutput("drop_drained", 32'(e0), 32'd1);
        checkOutput("ow_drained", 32'(e_ow), 32'd1);

        // Change-only filter.
        doReset();
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
        checkOutput("chg_count", 32'(c_chg), 32'd3);
        checkOutput("nochg_count", 32'(c0), 32'd6);
        checkOutput("chg_w0", d_chg, 32'd4);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("chg_w1", d_chg, 32'd9);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("chg_w2", d_chg, 32'd4);

        // Full buffer with simultaneous push and pop.
        doReset();
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b1);
        checkOutput("pp_count", 32'(c0), 32'd16);
        checkOutput("pp_ovf", 32'(o0), 32'd0);
        checkOutput("pp_ow_ovf", 32'(o_ow), 32'd0);
        for (int i = 0; i < 15; i++) begin
            checkOutput("pp_order", d0, 32'(2 + i));
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        end
        checkOutput("pp_last", d0, 32'hAA);
        checkOutput("pp_ow_last", d_ow, 32'hAA);

        // Back-to-back streaming with the consumer always ready.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(100 + i), 1'b0, 1'b1);
            checkOutput("stream_data", d0, 32'(100 + i));
            checkOutput("stream_count", 32'(c0), 32'd1);
        end
        checkOutput("stream_ovf", 32'(o0), 32'd0);

        // Clear with simultaneous push and pop, then reset mid-drain.
        doReset();
        for (int i = 1; i <= 19; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("pre_clr_count", 32'(c0), 32'd8);
        checkOutput("pre_clr_ovf", 32'(o0), 32'd3);
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b1);
        checkOutput("clr_count", 32'(c0), 32'd0);
        checkOutput("clr_ovf", 32'(o0), 32'd0);
        checkOutput("clr_valid", 32'(v0), 32'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("mid_head", d0, 32'd2);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b1);
        reset = 1'b0;
        checkOutput("rst_count", 32'(c0), 32'd0);
        checkOutput("rst_valid", 32'(v0), 32'd0);
        checkOutput("rst_ovf", 32'(o0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
